data_memory_bytelane: RTL and testbench
=======================================

// Module: data_memory_bytelane
// PURPOSE
//  RV32I load/store data memory for the single-cycle/pipelined core, replacing the word-only RAM.
//  Adds byte/halfword stores with lane enables, sign/zero-extended sub-word loads, and a
//  configurable read latency. Detects misalignment and out-of-range accesses.
//  Clears memory on reset through a one-word-per-cycle sweep FSM rather than a single-cycle loop.
//  Sits between the ALU result/bypass paths and the writeback mux.
// PARAMETERS
//  DEPTH_WORDS    256  number of 32-bit words, power of 2 >= 4; AW = $clog2(DEPTH_WORDS)
//  READ_LATENCY   1    0 = combinational read data; 1 = registered read data plus read_valid
//  CLEAR_ON_RESET 1    1 = sweep-zero RAM after reset; 0 = RAM contents retained across reset
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  byte_address  in   32  byte address from ALU result
//  write_data    in   32  store data from ALU bypass; byte/half taken from low bits
//  MemWrite      in   1   store request this cycle
//  MemRead       in   1   load request this cycle
//  funct3        in   3   access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  output_data   out  32  load result, already extended to 32 bits
//  read_valid    out  1   load result valid (LAT=1: 1 cycle after request; LAT=0: same cycle)
//  busy          out  1   clear sweep in progress; all requests ignored
//  misaligned    out  1   combinational: current request is misaligned
//  fault         out  1   combinational: out-of-range address or illegal funct3 for the op
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state<=CLEAR (or READY if CLEAR_ON_RESET=0), clr_idx<=0,
//    output_data<=0, read_valid<=0. busy=1 in CLEAR. Reset during CLEAR restarts sweep at 0.
//  - FSM CLEAR: each cycle ram[clr_idx]<=0, clr_idx++; when clr_idx==DEPTH_WORDS-1 -> READY.
//    Sweep takes exactly DEPTH_WORDS cycles; busy is 0 from the next cycle on.
//    READY: serves requests; exits only on rst.
//  - word index = byte_address[AW+1:2]; lane = byte_address[1:0].
//  - Out of range: any byte_address bit above AW+1 set -> fault=1. Store suppressed; load returns 0.
//  - Misaligned: H/HU with lane[0]=1, W with lane!=0 -> misaligned=1. Store suppressed; load returns 0.
//  - Illegal funct3 (011,110,111, or 100/101 with MemWrite) -> fault=1, no RAM change, load returns 0.
//  - Store: SB writes byte lane L with write_data[7:0]; SH writes lanes {lane+1,lane} with
//    write_data[15:0]; SW writes all 4 lanes. Untouched lanes are preserved (byte-enable write).
//  - Load: select the byte/half at lane. B/H sign-extend, BU/HU zero-extend, W passes through.
//  - LAT=1: output_data/read_valid registered at the edge after the request (1-cycle latency).
//    When no load is accepted, read_valid=0 and output_data holds its last value.
//  - LAT=0: output_data combinational from current RAM; read_valid=MemRead&~busy;
//    output_data=0 whenever read_valid=0.
//  - MemRead & MemWrite to the same word in one cycle: load returns pre-write (old) data;
//    the store completes at that edge.
//  - While busy: MemWrite/MemRead ignored, read_valid=0, misaligned/fault forced to 0.
//  - misaligned and fault are evaluated only when MemRead|MemWrite; otherwise 0.
// TESTING
//  1 Reset sweep: rst 1 cycle, DEPTH_WORDS=256 -> busy=1 for exactly 256 cycles; afterwards
//    LW from addr 0x3FC returns 0x00000000.
//  2 Byte lanes: SW 0x11223344 @0x10; SB 0xAA @0x12 -> LW @0x10 = 0x11AA3344.
//    SH 0xBEEF @0x10 -> LW = 0x11AABEEF.
//  3 Extension: word 0x80F07F01 @0x20 -> LB @0x23 = 0xFFFFFF80, LBU @0x23 = 0x00000080,
//    LH @0x22 = 0xFFFF80F0, LHU @0x20 = 0x00007F01.
//  4 Misalign/range: SW @0x22 -> misaligned=1, word unchanged;
//    LW @0x400 (DEPTH 256) -> fault=1, data 0.
//  5 Read-during-write: word 0x5 @0x40; same cycle SW 0x9 + LW @0x40 -> load returns 0x5;
//    next LW returns 0x9. Run for both LAT=0 and LAT=1, checking read_valid timing.
//  6 Reset mid-sweep: assert rst at sweep cycle 100 -> busy stays 1 for 256 more cycles;
//    requests during busy have no effect.

Source files
------------

// File: rtl/data_memory_bytelane.sv
// RV32I data memory with byte-lane stores, extended sub-word loads, selectable read latency
// and a one-word-per-cycle clear sweep after reset.
module data_memory_bytelane #(
    parameter int DEPTH_WORDS    = 256,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] byte_address,
    input  logic [31:0] write_data,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    output logic [31:0] output_data,
    output logic        read_valid,
    output logic        busy,
    output logic        misaligned,
    output logic        fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_READY = 1'b1;
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH_WORDS - 1);
    localparam logic [AW-1:0] CLR_ONE  = AW'(1);
    localparam logic [2:0]    F3_B  = 3'b000;
    localparam logic [2:0]    F3_H  = 3'b001;
    localparam logic [2:0]    F3_W  = 3'b010;
    localparam logic [2:0]    F3_BU = 3'b100;
    localparam logic [2:0]    F3_HU = 3'b101;

    logic [0:0]    state_r;
    logic [AW-1:0] clr_idx_r;
    logic [31:0]   mem_r [DEPTH_WORDS];

    logic [AW-1:0] word_idx_s;
    logic [1:0]    lane_s;
    logic          req_s, legal_s, oor_s, mis_raw_s, data_ok_s, store_ok_s;
    logic [3:0]    be_s;
    logic [31:0]   wlane_s, rd_word_s, load_val_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;

    assign busy       = (state_r == ST_CLEAR);
    assign word_idx_s = byte_address[AW+1:2];
    assign lane_s     = byte_address[1:0];
    assign rd_word_s  = mem_r[word_idx_s];
    assign byte_s     = rd_word_s[{lane_s, 3'b000} +: 8];
    assign half_s     = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

    // Request decode: legality, alignment and range; flags are silent while sweeping
    always_comb begin
        req_s = (MemRead | MemWrite) & ~busy;
        oor_s = (byte_address >> (AW + 2)) != 32'd0;
        case (funct3)
            F3_B:    begin legal_s = 1'b1;      mis_raw_s = 1'b0;       end
            F3_H:    begin legal_s = 1'b1;      mis_raw_s = lane_s[0];  end
            F3_W:    begin legal_s = 1'b1;      mis_raw_s = |lane_s;    end
            F3_BU:   begin legal_s = ~MemWrite; mis_raw_s = 1'b0;       end
            F3_HU:   begin legal_s = ~MemWrite; mis_raw_s = lane_s[0];  end
            default: begin legal_s = 1'b0;      mis_raw_s = 1'b0;       end
        endcase
        misaligned = req_s & mis_raw_s;
        fault      = req_s & (oor_s | ~legal_s);
        data_ok_s  = legal_s & ~mis_raw_s & ~oor_s;
        store_ok_s = MemWrite & req_s & data_ok_s;
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        case (funct3)
            F3_B:    begin be_s = 4'b0001 << lane_s;                   wlane_s = {4{write_data[7:0]}};  end
            F3_H:    begin be_s = lane_s[1] ? 4'b1100 : 4'b0011;       wlane_s = {2{write_data[15:0]}}; end
            F3_W:    begin be_s = 4'b1111;                             wlane_s = write_data;            end
            default: begin be_s = 4'b0000;                             wlane_s = write_data;            end
        endcase
    end

    // Load extraction and extension; rejected accesses read as zero
    always_comb begin
        case (funct3)
            F3_B:    load_val_s = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_val_s = {24'd0, byte_s};
            F3_H:    load_val_s = {{16{half_s[15]}}, half_s};
            F3_HU:   load_val_s = {16'd0, half_s};
            F3_W:    load_val_s = rd_word_s;
            default: load_val_s = 32'd0;
        endcase
        if (!data_ok_s) begin
            load_val_s = 32'd0;
        end else begin
            load_val_s = load_val_s;
        end
    end

    // Sweep / reset state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_idx_r <= '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + CLR_ONE;
                    if (clr_idx_r == CLR_LAST) state_r <= ST_READY;
                end
                ST_READY: state_r <= ST_READY;
                default:  state_r <= ST_CLEAR;
            endcase
        end
    end

    // RAM array: sweep zeroing or byte-enabled store
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_idx_r] <= 32'd0;
            end else if (store_ok_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_s[i]) mem_r[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign read_valid  = MemRead & ~busy;
            assign output_data = read_valid ? load_val_s : 32'd0;
        end else begin : g_reg_read
            // Registered read port; old data is seen on read-during-write
            always_ff @(posedge clk) begin
                if (rst) begin
                    output_data <= 32'd0;
                    read_valid  <= 1'b0;
                end else if (MemRead && !busy) begin
                    output_data <= load_val_s;
                    read_valid  <= 1'b1;
                end else begin
                    read_valid  <= 1'b0;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: latency-1 and latency-0 instances share one stimulus stream
// and are checked against a byte-array reference model.
module tb_data_memory_bytelane;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, MemWrite, MemRead;
    logic [2:0]  funct3;
    logic [31:0] byte_address, write_data;
    logic [31:0] od1, od0;
    logic        rv1, busy1, mis1, flt1, rv0, busy0, mis0, flt0;

    int tests = 0;
    int fails = 0;
    logic [7:0]  mdl [0:4*DEPTH-1];
    logic [31:0] exp_od1;
    logic        exp_rv1;
    logic [31:0] obs_od0;
    logic        obs_rv0, obs_mis, obs_flt, obs_rv1_pre;

    always #5 clk = ~clk;

    data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .byte_address(byte_address), .write_data(write_data),
        .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3), .output_data(od1),
        .read_valid(rv1), .busy(busy1), .misaligned(mis1), .fault(flt1));

    data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .byte_address(byte_address), .write_data(write_data),
        .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3), .output_data(od0),
        .read_valid(rv0), .busy(busy0), .misaligned(mis0), .fault(flt0));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int size;
        logic [31:0] v;
        logic [9:0] idx;
        size = 1 << f3[1:0];
        v = 32'd0;
        for (int k = 0; k < size; k++) begin
            idx = a[9:0] + 10'(k);
            v = v | ({24'd0, mdl[idx]} << (8 * k));
        end
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic idle();
        MemWrite = 1'b0; MemRead = 1'b0; funct3 = 3'd2;
        byte_address = 32'd0; write_data = 32'd0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4 * DEPTH; i++) mdl[i] = 8'd0;
        exp_od1 = 32'd0;
        exp_rv1 = 1'b0;
    endtask

    // One request cycle: combinational checks before the edge, registered checks after it
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
        logic legal, oor, mis, req;
        logic [31:0] ld;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; byte_address = a; write_data = wd;
        #1;
        req   = rd | wr;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (((f3 == 3'd4) || (f3 == 3'd5)) && !wr);
        oor   = a >= 32'(4 * DEPTH);
        mis   = (((f3 == 3'd1) || (f3 == 3'd5)) && (a % 2 != 0)) || ((f3 == 3'd2) && (a % 4 != 0));
        ld    = (legal && !oor && !mis) ? ref_load(f3, a) : 32'd0;
        obs_od0 = od0; obs_rv0 = rv0; obs_mis = mis1; obs_flt = flt1; obs_rv1_pre = rv1;
        check("busy", 32'(busy1), 32'd0);
        check("mis_lat1", 32'(mis1), 32'(req & mis));
        check("mis_lat0", 32'(mis0), 32'(req & mis));
        check("fault_lat1", 32'(flt1), 32'(req & (oor | !legal)));
        check("fault_lat0", 32'(flt0), 32'(req & (oor | !legal)));
        check("rv_lat0", 32'(rv0), 32'(rd));
        check("data_lat0", od0, rd ? ld : 32'd0);
        if (rd) begin
            exp_rv1 = 1'b1; exp_od1 = ld;
        end else begin
            exp_rv1 = 1'b0;
        end
        if (wr && legal && !oor && !mis) begin
            for (int k = 0; k < (1 << f3[1:0]); k++) mdl[a[9:0] + 10'(k)] = wd[8*k +: 8];
        end
        @(posedge clk);
        #1;
        check("rv_lat1", 32'(rv1), 32'(exp_rv1));
        check("data_lat1", od1, exp_od1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        check("rst_rv", 32'(rv1), 32'd0);
        check("rst_data", od1, 32'd0);
        check("rst_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        int n, bad;
        logic [2:0] f3;
        logic [31:0] a;
        rst = 1'b1;
        idle();
        clear_model();
        repeat (2) @(posedge clk);

        // Sweep length after a single reset
        pulse_reset();
        n = 0;
        while (busy1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("t1_busy_cycles", 32'(n), 32'd256);
        check("t1_busy_lat0", 32'(busy0), 32'd0);
        op(1'b1, 1'b0, 3'd2, 32'h3FC, 32'd0);
        check("t1_lw_3fc", od1, 32'h0000_0000);

        // Byte-lane stores
        op(1'b0, 1'b1, 3'd2, 32'h10, 32'h1122_3344);
        op(1'b0, 1'b1, 3'd0, 32'h12, 32'h0000_00AA);
        op(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        check("t2_sb", od1, 32'h11AA_3344);
        check("t2_sb_lat0", obs_od0, 32'h11AA_3344);
        op(1'b0, 1'b1, 3'd1, 32'h10, 32'h0000_BEEF);
        op(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        check("t2_sh", od1, 32'h11AA_BEEF);

        // Sign and zero extension
        op(1'b0, 1'b1, 3'd2, 32'h20, 32'h80F0_7F01);
        op(1'b1, 1'b0, 3'd0, 32'h23, 32'd0);
        check("t3_lb", od1, 32'hFFFF_FF80);
        op(1'b1, 1'b0, 3'd4, 32'h23, 32'd0);
        check("t3_lbu", od1, 32'h0000_0080);
        op(1'b1, 1'b0, 3'd1, 32'h22, 32'd0);
        check("t3_lh", od1, 32'hFFFF_80F0);
        op(1'b1, 1'b0, 3'd5, 32'h20, 32'd0);
        check("t3_lhu", od1, 32'h0000_7F01);

        // Misalignment and range
        op(1'b0, 1'b1, 3'd2, 32'h22, 32'hCAFE_BABE);
        check("t4_sw_mis", 32'(obs_mis), 32'd1);
        op(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
        check("t4_word_kept", od1, 32'h80F0_7F01);
        op(1'b1, 1'b0, 3'd2, 32'h400, 32'd0);
        check("t4_oor_fault", 32'(obs_flt), 32'd1);
        check("t4_oor_data", od1, 32'd0);

        // Read during write returns old data
        op(1'b0, 1'b1, 3'd2, 32'h40, 32'h5);
        op(1'b1, 1'b1, 3'd2, 32'h40, 32'h9);
        check("t5_rdw_lat1", od1, 32'h5);
        check("t5_rdw_lat0", obs_od0, 32'h5);
        check("t5_rv_lat0_same", 32'(obs_rv0), 32'd1);
        check("t5_rv_lat1_pre", 32'(obs_rv1_pre), 32'd0);
        op(1'b1, 1'b0, 3'd2, 32'h40, 32'd0);
        check("t5_new_lat1", od1, 32'h9);
        check("t5_new_lat0", obs_od0, 32'h9);

        // Reset mid-sweep restarts it; requests while busy do nothing
        pulse_reset();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        bad = 0;
        while (busy1 && n < 1000) begin
            MemWrite = 1'b1; MemRead = 1'b1; funct3 = 3'd2;
            byte_address = n[0] ? 32'h2 : 32'h0; write_data = 32'hDEAD_BEEF;
            #1;
            if (mis1 || flt1 || mis0 || flt0 || rv0 || rv1 || od0 != 32'd0) bad++;
            n++;
            @(negedge clk);
        end
        idle();
        check("t6_busy_cycles", 32'(n), 32'd256);
        check("t6_busy_quiet", 32'(bad), 32'd0);
        op(1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
        check("t6_word0", od1, 32'd0);
        op(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        check("t6_swept", od1, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1100)) : 32'($urandom_range(0, 63));
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a, 32'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
